mem_wait_ram: RTL and testbench
===============================

# mem_wait_ram

Parametrised single-port synchronous RAM with a read/write request handshake, a programmable wait-state counter and a one-cycle `ready` completion pulse. It is the next-generation memory behind the CPU's MAR/MDR path. It replaces a combinational array with a clocked block that the control unit polls for completion. Depth, data width and access latency are parameters, so one block serves both fast simulation and realistic-latency runs.

## Interface
Parameters:
- `DATA_W`, 32, word width in bits; must be a multiple of 8.
- `DEPTH`, 512, number of words; addresses `0..DEPTH-1` are valid.
- `WAIT_CYCLES`, 1, extra wait states per access, range 0..15.

Ports:
- `clk`  in  1  system clock; all state changes on the rising edge.
- `clr`  in  1  reset, asynchronous, active-low.
- `address`  in  32  word address from MAR.
- `data_in`  in  DATA_W  write data from MDR.
- `read`  in  1  read request.
- `write`  in  1  write request; wins over `read` if both are high.
- `data_out`  out  DATA_W  read data, registered.
- `ready`  out  1  one-cycle completion pulse.
- `busy`  out  1  high whenever the block is not in IDLE.
- `err`  out  1  pulses with `ready` when the access was out of range.

## Operation
- The FSM has three states: IDLE, BUSY and DONE. Reset state is IDLE.
- IDLE:
  - If `write|read` is high at an edge, the block latches `address`, `data_in` and the operation (write if `write`=1, else read).
  - It loads the wait counter with `WAIT_CYCLES` and moves to BUSY.
  - Otherwise it stays in IDLE.
- BUSY:
  - If counter ≠ 0, the counter decrements.
  - If counter = 0, the block performs the access and moves to DONE.
- Access rules:
  - Write with in-range address: `mem[addr] <= data`.
  - Read with in-range address: `data_out <= mem[addr]`.
  - Out-of-range (latched address ≥ DEPTH): memory is unchanged. On a read, `data_out <= 0`. `err` is set.
- DONE: `ready`=1 (and `err` if flagged) for exactly this state. The next edge returns to IDLE unconditionally.
- The block ignores `read`/`write` while in BUSY or DONE. Inputs are sampled only at acceptance, so changes after acceptance have no effect.
- The requester must drop its request before the edge that leaves DONE. A request still high in IDLE is accepted again as a new access.
- `data_out` holds the last read result until the next read completes. Writes do not disturb it.
- Memory contents are not cleared by reset and are X in simulation unless loaded.
- Address arithmetic: the comparison against DEPTH uses all 32 address bits. Indexing uses the low `$clog2(DEPTH)` bits.

## Timing
- Request sampled high at edge N:
  - The access occurs at edge N+1+WAIT_CYCLES.
  - `ready` is high from that edge until edge N+2+WAIT_CYCLES.
- Earliest back-to-back acceptance is edge N+3+WAIT_CYCLES. Throughput is one access per WAIT_CYCLES+3 cycles.
- `busy` is high from edge N to edge N+2+WAIT_CYCLES.
- Reset values: `data_out`=0, `ready`=0, `busy`=0, `err`=0, state IDLE, counter 0.
- Reset mid-access (`clr` low in BUSY or DONE): outputs go to reset values immediately. A pending write is abandoned, so memory is unchanged. No `ready` pulse is produced.
- `read` and `write` both high at acceptance: the block performs a single write with no error.
- WAIT_CYCLES=0: BUSY lasts one cycle. The access is at edge N+1.

## Configuration
- `MEM_BYTE_WE_EN` defined:
  - Adds input `byte_en` [DATA_W/8-1:0], latched at acceptance.
  - A write updates only the bytes whose enable is 1. All-zero enables perform no update but still produce `ready`.
  - Reads return the full word.
- `MEM_BYTE_WE_EN` undefined: the `byte_en` port is absent and every write updates the full word.

## Test plan
- WAIT_CYCLES=1. Reset, then write 0xDEADBEEF to addr 0x43 at edge 2 → `ready` high during cycle after edge 4. Read 0x43 → `data_out`=0xDEADBEEF with `ready`, `err`=0.
- WAIT_CYCLES=3. Read addr 5, holding `read` for one cycle → `busy` high 5 cycles, `ready` high exactly 1 cycle at edge N+4. Toggling `address` during BUSY has no effect.
- Read address 0x200 (=DEPTH) → `data_out`=0 and `err`=1 with `ready`. Write 0x1234 to 0x200 → no word changes (read back 0x000 still holds prior value).
- `read`=`write`=1 with addr 7, `data_in`=0x55 → single write. A subsequent read of 7 returns 0x55.
- Assert `clr`=0 in BUSY of a write to addr 9 (prior value 0x11) → outputs 0 immediately, no `ready`. Read of 9 after release returns 0x11.
- With `MEM_BYTE_WE_EN`: write 0xAABBCCDD with `byte_en`=4'b0101 over 0x00000000 → read returns 0x00BB00DD.

Source files
------------

// File: rtl/mem_wait_ram.sv
// Single-port synchronous RAM with request handshake, programmable wait states
// and a one-cycle ready pulse. Optional per-byte write enables via MEM_BYTE_WE_EN.
module mem_wait_ram #(
    parameter int DATA_W      = 32,
    parameter int DEPTH       = 512,
    parameter int WAIT_CYCLES = 1     // 0..15
) (
    input  logic                clk,
    input  logic                clr,
    input  logic [31:0]         address,
    input  logic [DATA_W-1:0]   data_in,
    input  logic                read,
    input  logic                write,
`ifdef MEM_BYTE_WE_EN
    input  logic [DATA_W/8-1:0] byte_en,
`endif
    output logic [DATA_W-1:0]   data_out,
    output logic                ready,
    output logic                busy,
    output logic                err,
    output logic [1:0]          state_dbg
);

    // Handshake: read/write form a request that is sampled only in IDLE; all
    // request fields are captured at that edge. ready pulses for exactly the one
    // DONE cycle, and the requester must drop its request before DONE ends.

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int NB = DATA_W / 8;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t              state;
    state_t              state_next;
    logic [3:0]          cnt;
    logic [31:0]         addr_q;
    logic [DATA_W-1:0]   din_q;
    logic                wr_q;
    logic                err_q;
`ifdef MEM_BYTE_WE_EN
    logic [NB-1:0]       be_q;
`endif
    logic [DATA_W-1:0]   mem [DEPTH];

    logic                accept;
    logic                access;
    logic                in_range;
    logic [AW-1:0]       idx;

    assign accept   = (state == S_IDLE) && (read || write);
    assign access   = (state == S_BUSY) && (cnt == 4'd0);
    // Range check uses the full address so aliased high addresses still flag err.
    assign in_range = (addr_q < 32'(DEPTH));
    assign idx      = addr_q[AW-1:0];

    always_ff @(posedge clk or negedge clr) begin
        if (!clr) state <= S_IDLE;
        else      state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            S_IDLE:  if (read || write) state_next = S_BUSY;
            S_BUSY:  if (cnt == 4'd0)   state_next = S_DONE;
            S_DONE:  state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            cnt      <= 4'd0;
            addr_q   <= 32'd0;
            din_q    <= '0;
            wr_q     <= 1'b0;
            err_q    <= 1'b0;
            data_out <= '0;
`ifdef MEM_BYTE_WE_EN
            be_q     <= '0;
`endif
        end else begin
            if (accept) begin
                cnt    <= 4'(WAIT_CYCLES);
                addr_q <= address;
                din_q  <= data_in;
                wr_q   <= write;
                err_q  <= 1'b0;
`ifdef MEM_BYTE_WE_EN
                be_q   <= byte_en;
`endif
            end else if ((state == S_BUSY) && (cnt != 4'd0)) begin
                cnt <= cnt - 4'd1;
            end
            if (access) begin
                err_q <= !in_range;
                if (!wr_q) data_out <= in_range ? mem[idx] : '0;
            end
        end
    end

    // Memory has no reset; a reset during BUSY leaves state IDLE so no write lands.
    always_ff @(posedge clk) begin
        if (access && wr_q && in_range) begin
`ifdef MEM_BYTE_WE_EN
            for (int b = 0; b < NB; b++) begin
                if (be_q[b]) mem[idx][b*8 +: 8] <= din_q[b*8 +: 8];
            end
`else
            mem[idx] <= din_q;
`endif
        end
    end

    assign ready     = (state == S_DONE);
    assign err       = (state == S_DONE) && err_q;
    assign busy      = (state != S_IDLE);
    assign state_dbg = state;

endmodule

// File: tb/tb_mem_wait_ram.sv
// Directed bench for mem_wait_ram: one instance with WAIT_CYCLES=1, one with 3.
// Byte-enable scenario is built only when MEM_BYTE_WE_EN is defined.
module tb_mem_wait_ram;

    logic        clk;
    logic        clr;

    logic [31:0] a_address, a_data_in, a_data_out;
    logic        a_read, a_write, a_ready, a_busy, a_err;
    logic [1:0]  a_state;
    logic [3:0]  a_byte_en;

    logic [31:0] b_address, b_data_in, b_data_out;
    logic        b_read, b_write, b_ready, b_busy, b_err;
    logic [1:0]  b_state;
    logic [3:0]  b_byte_en;

    int          passed;
    int          total;
    logic [31:0] last_rd;

    mem_wait_ram #(.DATA_W(32), .DEPTH(512), .WAIT_CYCLES(1)) dut (
        .clk(clk), .clr(clr), .address(a_address), .data_in(a_data_in),
        .read(a_read), .write(a_write),
`ifdef MEM_BYTE_WE_EN
        .byte_en(a_byte_en),
`endif
        .data_out(a_data_out), .ready(a_ready), .busy(a_busy), .err(a_err),
        .state_dbg(a_state)
    );

    mem_wait_ram #(.DATA_W(32), .DEPTH(512), .WAIT_CYCLES(3)) dut3 (
        .clk(clk), .clr(clr), .address(b_address), .data_in(b_data_in),
        .read(b_read), .write(b_write),
`ifdef MEM_BYTE_WE_EN
        .byte_en(b_byte_en),
`endif
        .data_out(b_data_out), .ready(b_ready), .busy(b_busy), .err(b_err),
        .state_dbg(b_state)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One access on the WAIT_CYCLES=1 instance; checks latency, pulse width,
    // err, and data_out (read result, or unchanged after a write).
    task automatic access(input logic wr, input logic rd, input logic [31:0] addr,
                          input logic [31:0] din, input logic [3:0] be,
                          input logic exp_err, input logic [31:0] exp_data,
                          input string name);
        int  k;
        bit  seen;
        logic [31:0] want;
        @(negedge clk);
        a_write = wr; a_read = rd; a_address = addr; a_data_in = din; a_byte_en = be;
        @(negedge clk);
        a_write = 1'b0; a_read = 1'b0;
        a_address = $urandom; a_data_in = $urandom; a_byte_en = 4'($urandom);
        total++;
        if (a_busy !== 1'b1) $display("FAIL %s busy_after_accept got=%b exp=1", name, a_busy);
        else passed++;
        k = 0; seen = 0;
        while (!seen && k < 20) begin
            if (a_ready === 1'b1) seen = 1;
            else begin @(negedge clk); k++; end
        end
        total++;
        if (!seen || k != 2) $display("FAIL %s ready_latency got=%0d exp=2 seen=%0d", name, k, seen);
        else passed++;
        total++;
        if (a_err !== exp_err) $display("FAIL %s err got=%b exp=%b", name, a_err, exp_err);
        else passed++;
        want = (rd && !wr) ? exp_data : last_rd;
        total++;
        if (a_data_out !== want) $display("FAIL %s data_out got=%h exp=%h", name, a_data_out, want);
        else passed++;
        if (rd && !wr) last_rd = exp_data;
        @(negedge clk);
        total++;
        if (a_ready !== 1'b0 || a_busy !== 1'b0 || a_err !== 1'b0)
            $display("FAIL %s after_done ready=%b busy=%b err=%b exp=0,0,0", name, a_ready, a_busy, a_err);
        else passed++;
    endtask

    task automatic test_reset();
        clr = 1'b0;
        a_read = 0; a_write = 0; a_address = 0; a_data_in = 0; a_byte_en = 4'hF;
        b_read = 0; b_write = 0; b_address = 0; b_data_in = 0; b_byte_en = 4'hF;
        repeat (2) @(negedge clk);
        total++;
        if (a_data_out !== 32'd0 || a_ready !== 1'b0 || a_busy !== 1'b0 || a_err !== 1'b0 || a_state !== 2'd0)
            $display("FAIL reset_values data_out=%h ready=%b busy=%b err=%b state=%0d exp=0", a_data_out, a_ready, a_busy, a_err, a_state);
        else passed++;
        clr = 1'b1;
        last_rd = 32'd0;
    endtask

    task automatic test_write_read();
        access(1, 0, 32'h43, 32'hDEADBEEF, 4'hF, 0, 32'h0, "wr_43");
        access(0, 1, 32'h43, 32'h0, 4'hF, 0, 32'hDEADBEEF, "rd_43");
        access(1, 0, 32'h1FF, 32'h0BADF00D, 4'hF, 0, 32'h0, "wr_1ff");
        access(0, 1, 32'h1FF, 32'h0, 4'hF, 0, 32'h0BADF00D, "rd_1ff");
    endtask

    task automatic test_out_of_range();
        access(1, 0, 32'h0, 32'hA5A5A5A5, 4'hF, 0, 32'h0, "wr_0");
        access(0, 1, 32'h200, 32'h0, 4'hF, 1, 32'h0, "rd_200");
        access(1, 0, 32'h200, 32'h1234, 4'hF, 1, 32'h0, "wr_200");
        access(0, 1, 32'h1000_0000, 32'h0, 4'hF, 1, 32'h0, "rd_high_alias");
        access(0, 1, 32'h0, 32'h0, 4'hF, 0, 32'hA5A5A5A5, "rd_0_after_oor");
    endtask

    task automatic test_read_write_both();
        access(1, 1, 32'h7, 32'h55, 4'hF, 0, 32'h0, "both_7");
        access(0, 1, 32'h7, 32'h0, 4'hF, 0, 32'h55, "rd_7");
    endtask

    task automatic test_wait_states();
        int k;
        int busy_cnt;
        int ready_cnt;
        int ready_k;
        bit seen;
        @(negedge clk);
        b_write = 1; b_address = 32'd5; b_data_in = 32'hCAFE0005;
        @(negedge clk);
        b_write = 0;
        k = 0; seen = 0;
        while (!seen && k < 20) begin
            if (b_ready === 1'b1) seen = 1;
            else begin @(negedge clk); k++; end
        end
        total++;
        if (!seen || k != 4) $display("FAIL w3_write_latency got=%0d exp=4 seen=%0d", k, seen);
        else passed++;
        @(negedge clk);
        b_read = 1; b_address = 32'd5;
        @(negedge clk);
        b_read = 0;
        busy_cnt = 0; ready_cnt = 0; ready_k = -1;
        for (int i = 0; i < 10; i++) begin
            if (b_busy === 1'b1) busy_cnt++;
            if (b_ready === 1'b1) begin
                ready_cnt++;
                ready_k = i;
                total++;
                if (b_data_out !== 32'hCAFE0005 || b_err !== 1'b0)
                    $display("FAIL w3_read_data got=%h err=%b exp=cafe0005 err=0", b_data_out, b_err);
                else passed++;
            end
            b_address = 32'($urandom_range(0, 511));
            @(negedge clk);
        end
        total++;
        if (busy_cnt != 5) $display("FAIL w3_busy_cycles got=%0d exp=5", busy_cnt);
        else passed++;
        total++;
        if (ready_cnt != 1 || ready_k != 4)
            $display("FAIL w3_ready_pulse count=%0d at=%0d exp count=1 at=4", ready_cnt, ready_k);
        else passed++;
    endtask

    task automatic test_reset_mid_access();
        bit saw_ready;
        access(1, 0, 32'h9, 32'h11, 4'hF, 0, 32'h0, "wr_9");
        access(0, 1, 32'h9, 32'h0, 4'hF, 0, 32'h11, "rd_9");
        @(negedge clk);
        a_write = 1; a_address = 32'h9; a_data_in = 32'h99;
        @(negedge clk);
        a_write = 0;
        clr = 1'b0;
        #1;
        total++;
        if (a_data_out !== 32'd0 || a_ready !== 1'b0 || a_busy !== 1'b0 || a_err !== 1'b0)
            $display("FAIL mid_reset_outputs data_out=%h ready=%b busy=%b err=%b exp=0", a_data_out, a_ready, a_busy, a_err);
        else passed++;
        saw_ready = 0;
        repeat (3) begin
            @(negedge clk);
            if (a_ready === 1'b1) saw_ready = 1;
        end
        clr = 1'b1;
        repeat (3) begin
            @(negedge clk);
            if (a_ready === 1'b1) saw_ready = 1;
        end
        total++;
        if (saw_ready) $display("FAIL mid_reset_no_ready got=1 exp=0");
        else passed++;
        last_rd = 32'd0;
        access(0, 1, 32'h9, 32'h0, 4'hF, 0, 32'h11, "rd_9_after_reset");
    endtask

`ifdef MEM_BYTE_WE_EN
    task automatic test_byte_enable();
        access(1, 0, 32'h20, 32'h0, 4'hF, 0, 32'h0, "be_clear");
        access(1, 0, 32'h20, 32'hAABBCCDD, 4'b0101, 0, 32'h0, "be_0101");
        access(0, 1, 32'h20, 32'h0, 4'h0, 0, 32'h00BB00DD, "be_rd");
        access(1, 0, 32'h20, 32'hFFFFFFFF, 4'b0000, 0, 32'h0, "be_none");
        access(0, 1, 32'h20, 32'h0, 4'h0, 0, 32'h00BB00DD, "be_rd2");
    endtask
`endif

    initial begin
        passed = 0;
        total  = 0;
        test_reset();
        test_write_read();
        test_out_of_range();
        test_read_write_both();
        test_wait_states();
`ifdef MEM_BYTE_WE_EN
        test_byte_enable();
`endif
        test_reset_mid_access();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
